// File: rtl/storage_access_arbiter.sv
// Round-robin arbiter sharing one registered-read record storage among N_REQ requesters.
// Define STORAGE_ARB_STATS_EN to add the txn_cnt / err_cnt statistics outputs.
module storage_access_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 64,
  parameter int MAX_ID = 8
) (
  input  logic                    clk,
  input  logic                    sys_rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [8*N_REQ-1:0]      req_id,
  input  logic [DATA_W*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]        ack,
  output logic                    err,
  output logic [DATA_W-1:0]       rdata,
  output logic [7:0]              st_rd_id,
  output logic [7:0]              st_wr_id,
  output logic [DATA_W-1:0]       st_wdata,
  input  logic [DATA_W-1:0]       st_rdata,
  output logic                    busy
`ifdef STORAGE_ARB_STATS_EN
  ,
  output logic [15:0]             txn_cnt,
  output logic [7:0]              err_cnt
`endif
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             we_reg;

  logic [7:0]        id_arr    [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];
  logic [N_REQ-1:0]  id_ok;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign id_arr[gi]    = req_id[8*gi +: 8];
      assign wdata_arr[gi] = req_wdata[DATA_W*gi +: DATA_W];
      assign id_ok[gi]     = (id_arr[gi] != 8'd0) && (int'(id_arr[gi]) <= MAX_ID);
    end
  endgenerate

  // First asserted request at or after ptr_reg, wrapping around.
  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_reg) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!grant_vld && req[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      idx_reg   <= '0;
      we_reg    <= 1'b0;
      ack       <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      st_rd_id  <= 8'd0;
      st_wr_id  <= 8'd0;
      st_wdata  <= '0;
    end else begin
      ack      <= '0;
      err      <= 1'b0;
      st_rd_id <= 8'd0;
      st_wr_id <= 8'd0;
      case (state_reg)
        IDLE: begin
          if (grant_vld) begin
            idx_reg  <= grant_idx;
            we_reg   <= req_we[grant_idx];
            st_wdata <= wdata_arr[grant_idx];
            if (id_ok[grant_idx]) begin
              state_reg <= ISSUE;
              if (req_we[grant_idx]) begin
                st_wr_id <= id_arr[grant_idx];
              end else begin
                st_rd_id <= id_arr[grant_idx];
              end
            end else begin
              // Illegal id: skip the storage entirely and complete with err.
              state_reg      <= DONE;
              ack[grant_idx] <= 1'b1;
              err            <= 1'b1;
            end
          end
        end
        ISSUE: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          state_reg    <= DONE;
          ack[idx_reg] <= 1'b1;
          if (!we_reg) begin
            rdata <= st_rdata;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          ptr_reg   <= (idx_reg == IDX_W'(N_REQ - 1)) ? '0 : idx_reg + 1'b1;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_reg != IDLE);

`ifdef STORAGE_ARB_STATS_EN
  logic [15:0] txn_cnt_reg;
  logic [7:0]  err_cnt_reg;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      txn_cnt_reg <= 16'd0;
      err_cnt_reg <= 8'd0;
    end else begin
      if ((|ack) && !err && (txn_cnt_reg != 16'hFFFF)) begin
        txn_cnt_reg <= txn_cnt_reg + 16'd1;
      end
      if (err && (err_cnt_reg != 8'hFF)) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end
  end

  assign txn_cnt = txn_cnt_reg;
  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_storage_access_arbiter.sv
// Directed self-checking bench for storage_access_arbiter with a registered-read storage model.
// Build with STORAGE_ARB_STATS_EN defined to also exercise the statistics counters.
module tb_storage_access_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 64;
  localparam int MAX_ID = 8;

  logic                    clk = 1'b0;
  logic                    sys_rst_n;
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_we;
  logic [8*N_REQ-1:0]      req_id;
  logic [DATA_W*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]        ack;
  logic                    err;
  logic [DATA_W-1:0]       rdata;
  logic [7:0]              st_rd_id;
  logic [7:0]              st_wr_id;
  logic [DATA_W-1:0]       st_wdata;
  logic [DATA_W-1:0]       st_rdata;
  logic                    busy;
`ifdef STORAGE_ARB_STATS_EN
  logic [15:0]             txn_cnt;
  logic [7:0]              err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  storage_access_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_ID(MAX_ID)) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_id    (req_id),
    .req_wdata (req_wdata),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .st_rd_id  (st_rd_id),
    .st_wr_id  (st_wr_id),
    .st_wdata  (st_wdata),
    .st_rdata  (st_rdata),
    .busy      (busy)
`ifdef STORAGE_ARB_STATS_EN
    ,
    .txn_cnt   (txn_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_val(input logic [7:0] id);
    return (id == 8'd3) ? 64'hA5 : {56'hC0DE0000000000, id};
  endfunction

  // Storage model: one-cycle registered read, write on a nonzero write id.
  logic [63:0] mem [256];
  bit          written [256];
  always @(posedge clk) begin
    st_rdata <= written[st_rd_id] ? mem[st_rd_id] : init_val(st_rd_id);
    if (st_wr_id != 8'd0) begin
      mem[st_wr_id]     <= st_wdata;
      written[st_wr_id] <= 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one request until its ack (bounded); leaves the bench in the DONE cycle with req dropped.
  task automatic do_txn(input int i, input logic we, input logic [7:0] id, input logic [63:0] wd,
                        output int lat, output logic [3:0] ack_seen, output logic err_seen,
                        output logic [63:0] rd_seen);
    req_we[i] = we;
    req_id[8*i +: 8] = id;
    req_wdata[64*i +: 64] = wd;
    req[i] = 1'b1;
    lat = 0;
    ack_seen = '0;
    err_seen = 1'b0;
    rd_seen = '0;
    while (ack_seen == 4'b0 && lat < 10) begin
      tick;
      lat++;
      ack_seen = ack;
      err_seen = err;
      rd_seen = rdata;
    end
    req[i] = 1'b0;
    $display("txn idx=%0d we=%0b id=%0d lat=%0d ack=%b err=%0b rdata=%h", i, we, id, lat, ack_seen, err_seen, rd_seen);
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    req = '0;
    req_we = '0;
    req_id = '0;
    req_wdata = '0;
    tick;
    tick;
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (st_rd_id !== 8'd0) begin errors++; $display("FAIL reset_st_rd_id: got %0d expected 0", st_rd_id); end
    checks++; if (st_wr_id !== 8'd0) begin errors++; $display("FAIL reset_st_wr_id: got %0d expected 0", st_wr_id); end
    checks++; if (st_wdata !== 64'd0) begin errors++; $display("FAIL reset_st_wdata: got %h expected 0", st_wdata); end
    checks++; if (rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    sys_rst_n = 1'b1;
    tick;
  endtask

  task automatic test_contention;
    int order [5] = '{0, 1, 2, 3, 0};
    int cnt;
    logic [3:0] a;
    for (int i = 0; i < N_REQ; i++) begin
      req_we[i] = 1'b0;
      req_id[8*i +: 8] = 8'(i + 1);
    end
    req = 4'b1111;
    cnt = 0;
    for (int n = 0; n < 5; n++) begin
      a = '0;
      while (a == 4'b0 && cnt < 12) begin
        tick;
        cnt++;
        a = ack;
      end
      $display("txn contention n=%0d ack=%b gap=%0d rdata=%h", n, a, cnt, rdata);
      checks++; if (a !== (4'b0001 << order[n])) begin errors++; $display("FAIL contention_ack n=%0d: got %b expected index %0d", n, a, order[n]); end
      checks++; if (cnt != ((n == 0) ? 3 : 4)) begin errors++; $display("FAIL contention_gap n=%0d: got %0d expected %0d", n, cnt, (n == 0) ? 3 : 4); end
      checks++; if (rdata !== init_val(8'(order[n] + 1))) begin errors++; $display("FAIL contention_rdata n=%0d: got %h expected %h", n, rdata, init_val(8'(order[n] + 1))); end
      req = req & ~a;
      tick;
      req = (n < 4) ? 4'b1111 : 4'b0000;
      cnt = 1;
    end
  endtask

  task automatic test_read;
    req_we[1] = 1'b0;
    req_id[15:8] = 8'd3;
    req[1] = 1'b1;
    tick;
    checks++; if (st_rd_id !== 8'd3) begin errors++; $display("FAIL read_issue_rd_id: got %0d expected 3", st_rd_id); end
    checks++; if (st_wr_id !== 8'd0) begin errors++; $display("FAIL read_issue_wr_id: got %0d expected 0", st_wr_id); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_issue_busy: got %b expected 1", busy); end
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL read_issue_ack: got %b expected 0000", ack); end
    req_id[15:8] = 8'd5;
    tick;
    checks++; if (st_rd_id !== 8'd0) begin errors++; $display("FAIL read_wait_rd_id: got %0d expected 0", st_rd_id); end
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL read_wait_ack: got %b expected 0000", ack); end
    tick;
    $display("txn read idx=1 id=3 ack=%b err=%0b rdata=%h", ack, err, rdata);
    checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL read_done_ack: got %b expected 0010", ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL read_done_err: got %b expected 0", err); end
    checks++; if (rdata !== 64'hA5) begin errors++; $display("FAIL read_done_rdata: got %h expected a5", rdata); end
    req[1] = 1'b0;
    tick;
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL read_idle_ack: got %b expected 0000", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_idle_busy: got %b expected 0", busy); end
    checks++; if (rdata !== 64'hA5) begin errors++; $display("FAIL read_idle_rdata: got %h expected a5", rdata); end
  endtask

  task automatic test_write;
    req_we[0] = 1'b1;
    req_id[7:0] = 8'd2;
    req_wdata[63:0] = 64'h1234;
    req[0] = 1'b1;
    tick;
    checks++; if (st_wr_id !== 8'd2) begin errors++; $display("FAIL write_issue_wr_id: got %0d expected 2", st_wr_id); end
    checks++; if (st_wdata !== 64'h1234) begin errors++; $display("FAIL write_issue_wdata: got %h expected 1234", st_wdata); end
    checks++; if (st_rd_id !== 8'd0) begin errors++; $display("FAIL write_issue_rd_id: got %0d expected 0", st_rd_id); end
    req_wdata[63:0] = 64'hDEAD;
    tick;
    checks++; if (st_wr_id !== 8'd0) begin errors++; $display("FAIL write_wait_wr_id: got %0d expected 0", st_wr_id); end
    checks++; if (st_rd_id !== 8'd0) begin errors++; $display("FAIL write_wait_rd_id: got %0d expected 0", st_rd_id); end
    checks++; if (st_wdata !== 64'h1234) begin errors++; $display("FAIL write_wait_wdata: got %h expected 1234", st_wdata); end
    req[0] = 1'b0;
    tick;
    $display("txn write idx=0 id=2 ack=%b err=%0b", ack, err);
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL write_done_ack: got %b expected 0001", ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL write_done_err: got %b expected 0", err); end
    checks++; if (st_rd_id !== 8'd0) begin errors++; $display("FAIL write_done_rd_id: got %0d expected 0", st_rd_id); end
    checks++; if (rdata !== 64'hA5) begin errors++; $display("FAIL write_done_rdata: got %h expected a5", rdata); end
    tick;
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL write_idle_ack: got %b expected 0000", ack); end
  endtask

  task automatic test_readback;
    int lat;
    logic [3:0] a;
    logic e;
    logic [63:0] rd;
    do_txn(1, 1'b0, 8'd2, 64'd0, lat, a, e, rd);
    checks++; if (a !== 4'b0010) begin errors++; $display("FAIL readback_ack: got %b expected 0010", a); end
    checks++; if (lat != 3) begin errors++; $display("FAIL readback_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 64'h1234) begin errors++; $display("FAIL readback_rdata: got %h expected 1234", rd); end
    tick;
    do_txn(2, 1'b0, 8'(MAX_ID), 64'd0, lat, a, e, rd);
    checks++; if (a !== 4'b0100 || e !== 1'b0) begin errors++; $display("FAIL maxid_ack: got ack=%b err=%b expected 0100/0", a, e); end
    checks++; if (lat != 3) begin errors++; $display("FAIL maxid_latency: got %0d expected 3", lat); end
    checks++; if (rd !== init_val(8'(MAX_ID))) begin errors++; $display("FAIL maxid_rdata: got %h expected %h", rd, init_val(8'(MAX_ID))); end
    tick;
  endtask

  task automatic test_illegal;
    logic [7:0] bad_ids [2] = '{8'd0, 8'(MAX_ID + 1)};
    for (int n = 0; n < 2; n++) begin
      req_we[2] = n[0];
      req_id[23:16] = bad_ids[n];
      req[2] = 1'b1;
      tick;
      $display("txn illegal idx=2 id=%0d ack=%b err=%0b", bad_ids[n], ack, err);
      checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL illegal_ack id=%0d: got %b expected 0100", bad_ids[n], ack); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err id=%0d: got %b expected 1", bad_ids[n], err); end
      checks++; if (st_rd_id !== 8'd0 || st_wr_id !== 8'd0) begin errors++; $display("FAIL illegal_st_ids id=%0d: got rd=%0d wr=%0d expected 0/0", bad_ids[n], st_rd_id, st_wr_id); end
      checks++; if (rdata !== init_val(8'(MAX_ID))) begin errors++; $display("FAIL illegal_rdata id=%0d: got %h expected %h", bad_ids[n], rdata, init_val(8'(MAX_ID))); end
      req[2] = 1'b0;
      tick;
      checks++; if (ack !== 4'b0 || err !== 1'b0) begin errors++; $display("FAIL illegal_idle id=%0d: got ack=%b err=%b expected 0000/0", bad_ids[n], ack, err); end
      checks++; if (st_rd_id !== 8'd0 || st_wr_id !== 8'd0) begin errors++; $display("FAIL illegal_idle_ids id=%0d: got rd=%0d wr=%0d expected 0/0", bad_ids[n], st_rd_id, st_wr_id); end
    end
  endtask

  task automatic test_reset_midop;
    int cnt;
    logic [3:0] a;
    req_we = '0;
    req_id[15:8] = 8'd4;
    req_id[31:24] = 8'd6;
    req = 4'b1010;
    tick;
    checks++; if (st_rd_id !== 8'd6) begin errors++; $display("FAIL midop_first_grant: got rd_id=%0d expected 6", st_rd_id); end
    tick;
    sys_rst_n = 1'b0;
    tick;
    checks++; if (ack !== 4'b0 || err !== 1'b0) begin errors++; $display("FAIL midop_reset_ack: got ack=%b err=%b expected 0000/0", ack, err); end
    checks++; if (st_rd_id !== 8'd0 || st_wr_id !== 8'd0) begin errors++; $display("FAIL midop_reset_ids: got rd=%0d wr=%0d expected 0/0", st_rd_id, st_wr_id); end
    checks++; if (st_wdata !== 64'd0 || rdata !== 64'd0) begin errors++; $display("FAIL midop_reset_data: got wdata=%h rdata=%h expected 0/0", st_wdata, rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midop_reset_busy: got %b expected 0", busy); end
    sys_rst_n = 1'b1;
    tick;
    checks++; if (st_rd_id !== 8'd4) begin errors++; $display("FAIL midop_restart_grant: got rd_id=%0d expected 4", st_rd_id); end
    tick;
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL midop_no_stale_ack: got %b expected 0000", ack); end
    tick;
    $display("txn after_reset idx=1 id=4 ack=%b rdata=%h", ack, rdata);
    checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL midop_restart_ack: got %b expected 0010", ack); end
    checks++; if (rdata !== init_val(8'd4)) begin errors++; $display("FAIL midop_restart_rdata: got %h expected %h", rdata, init_val(8'd4)); end
    req[1] = 1'b0;
    a = '0;
    cnt = 0;
    while (a == 4'b0 && cnt < 10) begin
      tick;
      cnt++;
      a = ack;
    end
    $display("txn pending idx=3 id=6 ack=%b rdata=%h", a, rdata);
    checks++; if (a !== 4'b1000) begin errors++; $display("FAIL midop_pending_ack: got %b expected 1000", a); end
    checks++; if (cnt != 4) begin errors++; $display("FAIL midop_pending_gap: got %0d expected 4", cnt); end
    checks++; if (rdata !== init_val(8'd6)) begin errors++; $display("FAIL midop_pending_rdata: got %h expected %h", rdata, init_val(8'd6)); end
    req[3] = 1'b0;
    tick;
  endtask

`ifdef STORAGE_ARB_STATS_EN
  task automatic test_stats;
    int lat;
    logic [3:0] a;
    logic e;
    logic [63:0] rd;
    sys_rst_n = 1'b0;
    tick;
    sys_rst_n = 1'b1;
    checks++; if (txn_cnt !== 16'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL stats_reset: got txn=%0d err=%0d expected 0/0", txn_cnt, err_cnt); end
    for (int n = 0; n < 3; n++) begin
      do_txn(n, 1'b0, 8'(n + 1), 64'd0, lat, a, e, rd);
      tick;
    end
    do_txn(3, 1'b0, 8'd0, 64'd0, lat, a, e, rd);
    tick;
    checks++; if (txn_cnt !== 16'd3) begin errors++; $display("FAIL stats_txn_cnt: got %0d expected 3", txn_cnt); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL stats_err_cnt: got %0d expected 1", err_cnt); end
    force dut.txn_cnt_reg = 16'hFFFF;
    tick;
    release dut.txn_cnt_reg;
    do_txn(0, 1'b0, 8'd1, 64'd0, lat, a, e, rd);
    tick;
    checks++; if (txn_cnt !== 16'hFFFF) begin errors++; $display("FAIL stats_txn_saturate: got %h expected ffff", txn_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_contention;
    test_read;
    test_write;
    test_readback;
    test_illegal;
    test_reset_midop;
`ifdef STORAGE_ARB_STATS_EN
    test_stats;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
